// File: rtl/motor_pkg.sv
// Shared types and helpers for the motor drive chain: FSM states, direction
// encoding, default counter width and duty sign/magnitude conversion.
package motor_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DEAD, FAULT} state_t;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  localparam int unsigned CNT_W_DEFAULT = 16;

  // |d| as 17-bit unsigned so that -32768 maps to 32768 without overflow.
  function automatic logic [16:0] duty_mag(input logic signed [15:0] d);
    logic [16:0] ext;
    ext = {d[15], d};
    return d[15] ? (~ext + 17'd1) : ext;
  endfunction

  function automatic logic [15:0] signed_duty(input logic [15:0] mag, input logic dir);
    return (dir == DIR_FWD) ? mag : (~mag + 16'd1);
  endfunction

endpackage

// File: rtl/pwm_counter.sv
// Edge-aligned PWM counter with shadow period register; flags the wrap point
// and emits a one-cycle period_start when a new period begins.
module pwm_counter import motor_pkg::*; #(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             start,
  input  logic             defer,
  input  logic             restart,
  input  logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] period_sh,
  output logic             wrap,
  output logic             period_start
);

  logic at_end;

  // A zero shadow period counts as a wrap every cycle so a new period can load.
  assign at_end = (period_sh == '0) || (cnt == period_sh - CNT_W'(1));
  assign wrap   = run && at_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      period_sh    <= '0;
      period_start <= 1'b0;
    end else begin
      cnt <= (run && !at_end) ? cnt + CNT_W'(1) : '0;
      if (start || wrap)
        period_sh <= period;
      period_start <= (wrap && (period_sh != '0) && !defer) || restart;
    end
  end

endmodule

// File: rtl/hbridge_pwm_driver.sv
// H-bridge PWM driver: double-buffered signed duty, dead-time on direction
// reversal and sticky fault shutdown, driving in1/in2 from registers.
module hbridge_pwm_driver import motor_pkg::*; #(
  parameter int unsigned DEADTIME_CYCLES = 100,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic signed [15:0] duty,
  input  logic               duty_valid,
  input  logic [CNT_W-1:0]   period,
  input  logic               fault,
  input  logic               fault_clr,
  output logic               in1,
  output logic               in2,
  output logic               dir,
  output logic               period_start,
  output logic signed [15:0] applied_duty,
  output logic               fault_latched
);

  localparam int unsigned DEAD_W = (DEADTIME_CYCLES > 1) ? $clog2(DEADTIME_CYCLES) : 1;

  state_t              state, state_n;
  logic [DEAD_W-1:0]   dead_cnt, dead_cnt_n;
  logic                pend_flag, pend_flag_n;
  logic signed [15:0]  duty_pend, duty_pend_n;
  logic [16:0]         mag, mag_n, hold_mag, hold_mag_n;
  logic                dir_n, hold_dir, hold_dir_n;
  logic signed [15:0]  applied_n;
  logic                fault_latched_n, in1_n, in2_n;

  logic                run, start, wrap, defer, restart, active, reversal;
  logic [CNT_W-1:0]    cnt, period_sh;
  logic                eff_valid, new_dir;
  logic signed [15:0]  eff_duty;
  logic [16:0]         raw_mag, new_mag;

  pwm_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .start        (start),
    .defer        (defer),
    .restart      (restart),
    .period       (period),
    .cnt          (cnt),
    .period_sh    (period_sh),
    .wrap         (wrap),
    .period_start (period_start)
  );

  // A strobe landing on the apply cycle is used directly (bypasses the buffer).
  assign eff_valid = pend_flag || duty_valid;
  assign eff_duty  = duty_valid ? duty : duty_pend;
  assign raw_mag   = duty_mag(eff_duty);
  assign new_mag   = (32'(raw_mag) > 32'(period)) ? 17'(period) : raw_mag;
  assign new_dir   = eff_duty[15] ? DIR_REV : DIR_FWD;

  assign run    = (state == RUN)  && enable && !fault;
  assign start  = (state == IDLE) && enable && !fault;
  assign active = (period_sh != '0) && (32'(cnt) < 32'(mag));

  assign reversal = (start || wrap) && eff_valid && (new_mag != '0) && (mag != '0)
                    && (new_dir != dir) && (DEADTIME_CYCLES != 0);
  assign defer    = reversal;

  always_comb begin
    state_n         = state;
    dead_cnt_n      = dead_cnt;
    pend_flag_n     = pend_flag;
    duty_pend_n     = duty_pend;
    mag_n           = mag;
    dir_n           = dir;
    hold_mag_n      = hold_mag;
    hold_dir_n      = hold_dir;
    applied_n       = applied_duty;
    fault_latched_n = fault_latched;
    in1_n           = 1'b0;
    in2_n           = 1'b0;
    restart         = 1'b0;

    if (duty_valid) begin
      pend_flag_n = 1'b1;
      duty_pend_n = duty;
    end

    if (start || wrap) begin
      if (start)
        state_n = RUN;
      if (eff_valid) begin
        pend_flag_n = 1'b0;
        if (reversal) begin
          state_n    = DEAD;
          dead_cnt_n = '0;
          hold_mag_n = new_mag;
          hold_dir_n = new_dir;
        end else begin
          mag_n     = new_mag;
          if (new_mag != '0)
            dir_n = new_dir;
          applied_n = signed_duty(new_mag[15:0], new_dir);
        end
      end
    end

    case (state)
      RUN: begin
        if (run) begin
          in1_n = (dir == DIR_FWD) && active;
          in2_n = (dir == DIR_REV) && active;
        end
      end
      DEAD: begin
        if (dead_cnt == DEAD_W'(DEADTIME_CYCLES - 1)) begin
          state_n   = RUN;
          mag_n     = hold_mag;
          dir_n     = hold_dir;
          applied_n = signed_duty(hold_mag[15:0], hold_dir);
          restart   = 1'b1;
        end else begin
          dead_cnt_n = dead_cnt + DEAD_W'(1);
        end
      end
      FAULT: begin
        if (fault_clr && !fault) begin
          state_n         = IDLE;
          fault_latched_n = 1'b0;
        end
      end
      default: ;
    endcase

    if (((state == RUN) || (state == DEAD)) && !enable) begin
      state_n     = IDLE;
      pend_flag_n = 1'b0;
      mag_n       = '0;
      applied_n   = '0;
      restart     = 1'b0;
    end

    if (fault) begin
      state_n         = FAULT;
      fault_latched_n = 1'b1;
      pend_flag_n     = 1'b0;
      mag_n           = '0;
      applied_n       = '0;
      in1_n           = 1'b0;
      in2_n           = 1'b0;
      restart         = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      dead_cnt      <= '0;
      pend_flag     <= 1'b0;
      duty_pend     <= '0;
      mag           <= '0;
      dir           <= 1'b0;
      hold_mag      <= '0;
      hold_dir      <= 1'b0;
      applied_duty  <= '0;
      fault_latched <= 1'b0;
      in1           <= 1'b0;
      in2           <= 1'b0;
    end else begin
      state         <= state_n;
      dead_cnt      <= dead_cnt_n;
      pend_flag     <= pend_flag_n;
      duty_pend     <= duty_pend_n;
      mag           <= mag_n;
      dir           <= dir_n;
      hold_mag      <= hold_mag_n;
      hold_dir      <= hold_dir_n;
      applied_duty  <= applied_n;
      fault_latched <= fault_latched_n;
      in1           <= in1_n;
      in2           <= in2_n;
    end
  end

endmodule

// File: tb/tb_hbridge_pwm_driver.sv
// Directed bench for hbridge_pwm_driver: forward PWM, reversal dead-time,
// clamping, double buffering, fault latch and boundary behaviour.
module tb_hbridge_pwm_driver;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enable;
  logic signed [15:0] duty;
  logic               duty_valid;
  logic [15:0]        period;
  logic               fault;
  logic               fault_clr;
  logic               in1, in2, dir, period_start, fault_latched;
  logic signed [15:0] applied_duty;

  int  errors = 0;
  int  checks = 0;
  int  both_cnt = 0;
  bit  cap1[1:100];
  bit  cap2[1:100];
  bit  capps[1:100];

  hbridge_pwm_driver #(.DEADTIME_CYCLES(100), .CNT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .duty          (duty),
    .duty_valid    (duty_valid),
    .period        (period),
    .fault         (fault),
    .fault_clr     (fault_clr),
    .in1           (in1),
    .in2           (in2),
    .dir           (dir),
    .period_start  (period_start),
    .applied_duty  (applied_duty),
    .fault_latched (fault_latched)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (in1 && in2) both_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture();
    for (int j = 1; j <= 100; j++) begin
      tick();
      cap1[j]  = in1;
      cap2[j]  = in2;
      capps[j] = period_start;
    end
  endtask

  // Runs until period_start is seen or the budget expires; optionally strobes a duty.
  task automatic run_period(input int strobe_at, input logic [15:0] sval, input int budget,
                            output bit found, output int elapsed, output int in1_hi,
                            output int in2_hi, output int last_in1);
    found = 1'b0; elapsed = budget; in1_hi = 0; in2_hi = 0; last_in1 = 0;
    for (int k = 1; k <= budget; k++) begin
      if (k - 1 == strobe_at) begin
        duty = sval;
        duty_valid = 1'b1;
      end else begin
        duty_valid = 1'b0;
      end
      tick();
      if (in1) begin in1_hi++; last_in1 = k; end
      if (in2) in2_hi++;
      if (period_start) begin found = 1'b1; elapsed = k; break; end
    end
    duty_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; duty = '0; duty_valid = 1'b0;
    period = 16'd100; fault = 1'b0; fault_clr = 1'b0;
    tick(); tick();
    checks++;
    if ({in1, in2, dir, period_start, fault_latched} !== 5'b0) begin
      errors++;
      $display("FAIL reset_bits: got %b, required 00000", {in1, in2, dir, period_start, fault_latched});
    end
    checks++;
    if (applied_duty !== 16'sd0) begin
      errors++;
      $display("FAIL reset_applied: got %0d, required 0", applied_duty);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_forward();
    bit found; int el, h1, h2, l1, bad;
    duty = 16'sd40; duty_valid = 1'b1; tick(); duty_valid = 1'b0;
    enable = 1'b1;
    run_period(-1, 16'd0, 300, found, el, h1, h2, l1);
    checks++;
    if (!found || el !== 101) begin
      errors++;
      $display("FAIL fwd_first_wrap: found=%0d after %0d, required 101", found, el);
    end
    checks++;
    if (dir !== 1'b1 || applied_duty !== 16'sd40) begin
      errors++;
      $display("FAIL fwd_state: dir=%0d applied=%0d, required 1/40", dir, applied_duty);
    end
    capture();
    bad = 0;
    for (int j = 1; j <= 100; j++)
      if (cap1[j] !== (j <= 40) || cap2[j] !== 1'b0 || capps[j] !== (j == 100)) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL fwd_pattern: %0d of 100 samples wrong, required 0", bad);
    end
  endtask

  task automatic test_reversal();
    bit found; int el, h1, h2, l1, bad;
    run_period(0, -16'sd30, 400, found, el, h1, h2, l1);
    checks++;
    if (!found || el !== 200 || h1 !== 40 || l1 !== 40 || h2 !== 0) begin
      errors++;
      $display("FAIL rev_deadtime: found=%0d el=%0d in1_hi=%0d last=%0d in2_hi=%0d, required 1/200/40/40/0",
               found, el, h1, l1, h2);
    end
    checks++;
    if (dir !== 1'b0 || applied_duty !== -16'sd30) begin
      errors++;
      $display("FAIL rev_state: dir=%0d applied=%0d, required 0/-30", dir, applied_duty);
    end
    capture();
    bad = 0;
    for (int j = 1; j <= 100; j++)
      if (cap2[j] !== (j <= 30) || cap1[j] !== 1'b0) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL rev_pattern: %0d of 100 samples wrong, required 0", bad);
    end
  endtask

  task automatic test_clamp();
    bit found; int el, h1, h2, l1, bad;
    run_period(0, 16'sd500, 400, found, el, h1, h2, l1);
    checks++;
    if (!found || el !== 200 || h2 !== 30 || h1 !== 0) begin
      errors++;
      $display("FAIL clamp_pos_wait: found=%0d el=%0d in1_hi=%0d in2_hi=%0d, required 1/200/0/30", found, el, h1, h2);
    end
    checks++;
    if (dir !== 1'b1 || applied_duty !== 16'sd100) begin
      errors++;
      $display("FAIL clamp_pos_state: dir=%0d applied=%0d, required 1/100", dir, applied_duty);
    end
    capture();
    bad = 0;
    for (int j = 1; j <= 100; j++) if (cap1[j] !== 1'b1 || cap2[j] !== 1'b0) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL clamp_pos_pattern: %0d of 100 samples wrong, required 0", bad);
    end
    run_period(0, 16'h8000, 400, found, el, h1, h2, l1);
    checks++;
    if (!found || el !== 200 || dir !== 1'b0 || applied_duty !== -16'sd100) begin
      errors++;
      $display("FAIL clamp_neg: found=%0d el=%0d dir=%0d applied=%0d, required 1/200/0/-100",
               found, el, dir, applied_duty);
    end
    capture();
    bad = 0;
    for (int j = 1; j <= 100; j++) if (cap2[j] !== 1'b1 || cap1[j] !== 1'b0) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL clamp_neg_pattern: %0d of 100 samples wrong, required 0", bad);
    end
  endtask

  task automatic test_double_buffer();
    bit found; int el, h1, h2, l1, bad;
    run_period(0, 16'sd0, 200, found, el, h1, h2, l1);
    checks++;
    if (!found || el !== 100 || dir !== 1'b0 || applied_duty !== 16'sd0) begin
      errors++;
      $display("FAIL coast: found=%0d el=%0d dir=%0d applied=%0d, required 1/100/0/0", found, el, dir, applied_duty);
    end
    duty = 16'sd20; duty_valid = 1'b1; tick(); duty_valid = 1'b0;
    run_period(29, 16'sd60, 200, found, el, h1, h2, l1);
    checks++;
    if (!found || el !== 99 || h1 !== 0 || h2 !== 0) begin
      errors++;
      $display("FAIL dbuf_no_glitch: found=%0d el=%0d in1_hi=%0d in2_hi=%0d, required 1/99/0/0", found, el, h1, h2);
    end
    checks++;
    if (dir !== 1'b1 || applied_duty !== 16'sd60) begin
      errors++;
      $display("FAIL dbuf_state: dir=%0d applied=%0d, required 1/60", dir, applied_duty);
    end
    capture();
    bad = 0;
    for (int j = 1; j <= 100; j++) if (cap1[j] !== (j <= 60) || cap2[j] !== 1'b0) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL dbuf_pattern: %0d of 100 samples wrong, required 0", bad);
    end
  endtask

  task automatic test_fault();
    bit found; int el, h1, h2, l1;
    repeat (5) tick();
    checks++;
    if (in1 !== 1'b1) begin
      errors++;
      $display("FAIL fault_pre_pulse: in1=%0d, required 1", in1);
    end
    fault = 1'b1;
    tick();
    checks++;
    if (in1 !== 1'b0 || in2 !== 1'b0 || fault_latched !== 1'b1 || applied_duty !== 16'sd0) begin
      errors++;
      $display("FAIL fault_entry: in1=%0d in2=%0d latched=%0d applied=%0d, required 0/0/1/0",
               in1, in2, fault_latched, applied_duty);
    end
    fault_clr = 1'b1;
    repeat (3) tick();
    checks++;
    if (fault_latched !== 1'b1 || in1 !== 1'b0) begin
      errors++;
      $display("FAIL fault_clr_ignored: latched=%0d in1=%0d, required 1/0", fault_latched, in1);
    end
    fault = 1'b0; fault_clr = 1'b0;
    tick();
    checks++;
    if (fault_latched !== 1'b1) begin
      errors++;
      $display("FAIL fault_sticky: latched=%0d, required 1", fault_latched);
    end
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    checks++;
    if (fault_latched !== 1'b0) begin
      errors++;
      $display("FAIL fault_cleared: latched=%0d, required 0", fault_latched);
    end
    run_period(0, 16'sd25, 300, found, el, h1, h2, l1);
    checks++;
    if (!found || el !== 101 || applied_duty !== 16'sd25 || dir !== 1'b1) begin
      errors++;
      $display("FAIL fault_rerun: found=%0d el=%0d applied=%0d dir=%0d, required 1/101/25/1",
               found, el, applied_duty, dir);
    end
  endtask

  task automatic test_boundaries();
    bit found; int el, h1, h2, l1;
    period = 16'd0;
    run_period(-1, 16'd0, 200, found, el, h1, h2, l1);
    checks++;
    if (!found || el !== 100) begin
      errors++;
      $display("FAIL p0_last_wrap: found=%0d el=%0d, required 1/100", found, el);
    end
    run_period(-1, 16'd0, 250, found, el, h1, h2, l1);
    checks++;
    if (found || h1 !== 0 || h2 !== 0) begin
      errors++;
      $display("FAIL p0_idle_out: found=%0d in1_hi=%0d in2_hi=%0d, required 0/0/0", found, h1, h2);
    end
    period = 16'd100;
    run_period(-1, 16'd0, 300, found, el, h1, h2, l1);
    checks++;
    if (!found || el !== 101) begin
      errors++;
      $display("FAIL p0_restore: found=%0d el=%0d, required 1/101", found, el);
    end
    repeat (10) tick();
    checks++;
    if (in1 !== 1'b1) begin
      errors++;
      $display("FAIL en_pre_drop: in1=%0d, required 1", in1);
    end
    enable = 1'b0;
    tick();
    checks++;
    if (in1 !== 1'b0 || in2 !== 1'b0 || applied_duty !== 16'sd0) begin
      errors++;
      $display("FAIL en_drop: in1=%0d in2=%0d applied=%0d, required 0/0/0", in1, in2, applied_duty);
    end
    duty = 16'sd40; duty_valid = 1'b1; tick(); duty_valid = 1'b0;
    enable = 1'b1;
    run_period(-1, 16'd0, 300, found, el, h1, h2, l1);
    checks++;
    if (!found || el !== 101 || applied_duty !== 16'sd40 || dir !== 1'b1) begin
      errors++;
      $display("FAIL en_restart: found=%0d el=%0d applied=%0d dir=%0d, required 1/101/40/1",
               found, el, applied_duty, dir);
    end
    run_period(0, -16'sd40, 150, found, el, h1, h2, l1);
    checks++;
    if (found || applied_duty !== 16'sd40 || dir !== 1'b1 || in1 !== 1'b0 || in2 !== 1'b0) begin
      errors++;
      $display("FAIL dead_hold: found=%0d applied=%0d dir=%0d in1=%0d in2=%0d, required 0/40/1/0/0",
               found, applied_duty, dir, in1, in2);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if ({in1, in2, dir, period_start, fault_latched} !== 5'b0 || applied_duty !== 16'sd0) begin
      errors++;
      $display("FAIL async_reset: bits=%b applied=%0d, required 00000/0",
               {in1, in2, dir, period_start, fault_latched}, applied_duty);
    end
    tick();
    rst_n = 1'b1;
    enable = 1'b0;
    tick();
  endtask

  task automatic test_invariant();
    checks++;
    if (both_cnt !== 0) begin
      errors++;
      $display("FAIL in1_in2_exclusive: %0d cycles with both high, required 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reversal();
    test_clamp();
    test_double_buffer();
    test_fault();
    test_boundaries();
    test_invariant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
